dsm_cic_decimator: RTL and testbench

- Receive-side reconstruction filter for the 3-level delta-sigma PWM code stream produced by the modulator (2-bit code: 00 = 0, 01 = +1, 11 = -1).
- Maps each code to a signed value and runs it through a 3rd-order CIC (sinc^3) decimator with ratio R = 2^LOG2_R.
- Emits one signed multi-bit sample per R accepted input codes, with a one-cycle valid strobe.
- Used for loopback checking of the modulator and as the digital demodulator on the receive path.

---
 rtl/dsm_cic_decimator.sv | 95 +++++++++
 tb/tb_dsm_cic_decimator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dsm_cic_decimator.sv
`default_nettype none
// ==========================================================================
// dsm_cic_decimator : 3-level delta-sigma code stream -> sinc^3 CIC decimator
// Revision 1.0
// ==========================================================================
module dsm_cic_decimator #(
  parameter  int LOG2_R = 6,
  localparam int W      = 2 + 3 * LOG2_R
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          pwm,
  input  logic                pwm_valid,
  input  logic                sync,
  output logic signed [W-1:0] dout,
  output logic                dout_valid,
  output logic                code_err
);

  localparam logic [LOG2_R-1:0] CNT_LAST = '1;
  localparam logic [1:0]        CODE_POS = 2'b01;
  localparam logic [1:0]        CODE_NEG = 2'b11;
  localparam logic [1:0]        CODE_BAD = 2'b10;

  logic [W-1:0]      i1_q, i2_q, i3_q;
  logic [W-1:0]      i1_d, i2_d, i3_d;
  logic [W-1:0]      d1_q, d2_q, d3_q;
  logic [W-1:0]      c1_d, c2_d, c3_d;
  logic [W-1:0]      dout_q;
  logic [W-1:0]      x_d;
  logic [LOG2_R-1:0] cnt_q;
  logic              valid_q;
  logic              err_q;
  logic              tick_d;

  // Integrators and combs wrap modulo 2^W; the comb differences cancel the wrap.
  always_comb begin
    x_d = '0;
    case (pwm)
      CODE_POS: x_d = {{(W-1){1'b0}}, 1'b1};
      CODE_NEG: x_d = '1;
      default:  x_d = '0;
    endcase
    i1_d   = i1_q + x_d;
    i2_d   = i2_q + i1_d;
    i3_d   = i3_q + i2_d;
    tick_d = pwm_valid & ~sync & (cnt_q == CNT_LAST);
    c1_d   = i3_d - d1_q;
    c2_d   = c1_d - d2_q;
    c3_d   = c2_d - d3_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      dout_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= tick_d;
      if (pwm_valid) begin
        i1_q <= i1_d;
        i2_q <= i2_d;
        i3_q <= i3_d;
      end
      // sync realigns the phase even when no sample is accepted
      if (sync) begin
        cnt_q <= '0;
      end else if (pwm_valid) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (tick_d) begin
        d1_q   <= i3_d;
        d2_q   <= c1_d;
        d3_q   <= c2_d;
        dout_q <= c3_d;
      end
      if (pwm_valid && (pwm == CODE_BAD)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign code_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_dsm_cic_decimator.sv
`default_nettype none
// ==========================================================================
// tb_dsm_cic_decimator : directed + random checks against a cumulative-sum model
// Revision 1.0
// ==========================================================================
module tb_dsm_cic_decimator;

  localparam int LOG2_R = 6;
  localparam int R      = 64;
  localparam int W      = 20;

  logic                clock = 1'b0;
  logic                reset = 1'b1;
  logic [1:0]          pwm = 2'b00;
  logic                pwm_valid = 1'b0;
  logic                sync = 1'b0;
  logic signed [W-1:0] dout;
  logic                dout_valid;
  logic                code_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: triple running sum of the sample values, sampled at decimation
  // instants, then the third finite difference of those samples.
  longint          s1, s2, s3, h0, h1, h2;
  int              since;
  logic            m_err;
  logic            m_valid;
  logic signed [W-1:0] m_dout;

  int cap_v[$];
  int cap_t[$];

  always #5 clock = ~clock;

  dsm_cic_decimator #(.LOG2_R(LOG2_R)) dut (
    .clock      (clock),
    .reset      (reset),
    .pwm        (pwm),
    .pwm_valid  (pwm_valid),
    .sync       (sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .code_err   (code_err)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  function automatic int capv(input int i);
    return (i < cap_v.size()) ? cap_v[i] : -999999;
  endfunction

  function automatic int capt(input int i);
    return (i < cap_t.size()) ? cap_t[i] : -999999;
  endfunction

  task automatic model_step(input bit rst, input bit v, input bit s, input logic [1:0] code);
    longint x;
    longint y;
    m_valid = 1'b0;
    if (rst) begin
      s1 = 0; s2 = 0; s3 = 0; h0 = 0; h1 = 0; h2 = 0;
      since = 0; m_err = 1'b0; m_dout = '0;
    end else begin
      if (v) begin
        x = (code == 2'b01) ? 1 : ((code == 2'b11) ? -1 : 0);
        if (code == 2'b10) m_err = 1'b1;
        s1 = s1 + x;
        s2 = s2 + s1;
        s3 = s3 + s2;
      end
      if (s) begin
        since = 0;
      end else if (v) begin
        since++;
        if (since == R) begin
          since = 0;
          y  = s3 - 3 * h0 + 3 * h1 - h2;
          h2 = h1; h1 = h0; h0 = s3;
          m_dout  = W'(y);
          m_valid = 1'b1;
        end
      end
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit s, input logic [1:0] code);
    reset = rst; pwm_valid = v; sync = s; pwm = code;
    @(posedge clock);
    #1;
    cyc++;
    model_step(rst, v, s, code);
    chk("dout_valid", int'(dout_valid), int'(m_valid));
    chk("dout", int'(dout), int'(m_dout));
    chk("code_err", int'(code_err), int'(m_err));
    if (dout_valid === 1'b1) begin
      cap_v.push_back(int'(dout));
      cap_t.push_back(cyc);
    end
  endtask

  initial begin
    int t0;
    logic [1:0] code;
    model_step(1'b1, 1'b0, 1'b0, 2'b00);

    repeat (3) step(1'b1, 1'b1, 1'b0, 2'b01);

    // DC +1 back to back
    cap_v.delete(); cap_t.delete(); t0 = cyc;
    repeat (300) step(1'b0, 1'b1, 1'b0, 2'b01);
    chk("pos_count", cap_v.size(), 4);
    chk("pos_first_lat", capt(0) - t0, R);
    chk("pos_o0", capv(0), 45760);
    chk("pos_o1", capv(1), 220480);
    chk("pos_o2", capv(2), 262144);
    chk("pos_o3", capv(3), 262144);
    chk("pos_gap", capt(1) - capt(0), R);

    // DC -1
    step(1'b1, 1'b0, 1'b0, 2'b00);
    cap_v.delete(); cap_t.delete();
    repeat (300) step(1'b0, 1'b1, 1'b0, 2'b11);
    chk("neg_o0", capv(0), -45760);
    chk("neg_o1", capv(1), -220480);
    chk("neg_o2", capv(2), -262144);
    chk("neg_o3", capv(3), -262144);

    // Alternating +1/-1: steady-state outputs are tiny
    step(1'b1, 1'b0, 1'b0, 2'b00);
    cap_v.delete(); cap_t.delete();
    repeat (160) begin
      step(1'b0, 1'b1, 1'b0, 2'b01);
      step(1'b0, 1'b1, 1'b0, 2'b11);
    end
    chk("alt_count", cap_v.size(), 5);
    for (int i = 2; i < cap_v.size(); i++)
      chk("alt_mag", int'(cap_v[i] <= 2 && cap_v[i] >= -2), 1);

    // All zero
    step(1'b1, 1'b0, 1'b0, 2'b00);
    cap_v.delete(); cap_t.delete();
    repeat (130) step(1'b0, 1'b1, 1'b0, 2'b00);
    chk("zero_count", cap_v.size(), 2);
    chk("zero_o0", capv(0), 0);
    chk("zero_o1", capv(1), 0);

    // Valid toggling 1/0
    step(1'b1, 1'b0, 1'b0, 2'b00);
    cap_v.delete(); cap_t.delete();
    repeat (260) begin
      step(1'b0, 1'b1, 1'b0, 2'b01);
      step(1'b0, 1'b0, 1'b0, 2'b11);
    end
    chk("tog_o0", capv(0), 45760);
    chk("tog_o1", capv(1), 220480);
    chk("tog_o2", capv(2), 262144);
    chk("tog_gap", capt(2) - capt(1), 2 * R);

    // sync realignment after 30 samples
    step(1'b1, 1'b0, 1'b0, 2'b00);
    repeat (30) step(1'b0, 1'b1, 1'b0, 2'b01);
    step(1'b0, 1'b1, 1'b1, 2'b01);
    cap_v.delete(); cap_t.delete();
    repeat (R - 1) step(1'b0, 1'b1, 1'b0, 2'b01);
    chk("sync_quiet", cap_v.size(), 0);
    step(1'b0, 1'b1, 1'b0, 2'b01);
    chk("sync_tick", int'(dout_valid), 1);

    // Illegal code and mid-frame reset
    step(1'b1, 1'b0, 1'b0, 2'b00);
    repeat (10) step(1'b0, 1'b1, 1'b0, 2'b01);
    chk("err_before", int'(code_err), 0);
    step(1'b0, 1'b1, 1'b0, 2'b10);
    chk("err_set", int'(code_err), 1);
    repeat (5) step(1'b0, 1'b0, 1'b0, 2'b01);
    chk("err_sticky", int'(code_err), 1);
    repeat (20) step(1'b0, 1'b1, 1'b0, 2'b01);
    step(1'b1, 1'b1, 1'b0, 2'b01);
    chk("rst_dout", int'(dout), 0);
    chk("rst_valid", int'(dout_valid), 0);
    chk("rst_err", int'(code_err), 0);
    cap_v.delete(); cap_t.delete();
    repeat (R) step(1'b0, 1'b1, 1'b0, 2'b01);
    chk("rst_restart", capv(0), 45760);

    // Random codes, valid gaps, occasional sync, rare illegal code and reset
    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 2))
        0:       code = 2'b00;
        1:       code = 2'b01;
        default: code = 2'b11;
      endcase
      if ($urandom_range(0, 499) == 0) code = 2'b10;
      step(($urandom_range(0, 1499) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 149) == 0), code);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
